// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter in front of a single SRAM controller port.
// Bounded bursts per grant, registered issue stage, tagged read-return pipeline.
module sram_arbiter #(
    parameter int ADDR_BITS    = 20,
    parameter int DATA_BITS    = 16,
    parameter int MAX_BURST    = 8,
    parameter int READ_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 p0_valid,
    output logic                 p0_ready,
    input  logic                 p0_we,
    input  logic [ADDR_BITS-1:0] p0_addr,
    input  logic [DATA_BITS-1:0] p0_wdata,
    output logic [DATA_BITS-1:0] p0_rdata,
    output logic                 p0_rvalid,
    input  logic                 p1_valid,
    output logic                 p1_ready,
    input  logic                 p1_we,
    input  logic [ADDR_BITS-1:0] p1_addr,
    input  logic [DATA_BITS-1:0] p1_wdata,
    output logic [DATA_BITS-1:0] p1_rdata,
    output logic                 p1_rvalid,
    output logic                 mem_valid,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [DATA_BITS-1:0] mem_wdata,
    input  logic [DATA_BITS-1:0] mem_read_data
);
    localparam int DEPTH = 1 + READ_LATENCY;

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

    state_t     state, state_nxt;
    logic       last, last_nxt;
    logic [7:0] burst_cnt, burst_nxt, burst_inc;
    logic       acc0, acc1, acc, acc_we;
    logic       own_valid, oth_valid;

    logic [DEPTH-1:0] tag_vld, tag_port;

    assign p0_ready = (state == GRANT0);
    assign p1_ready = (state == GRANT1);
    assign acc0     = p0_valid & p0_ready;
    assign acc1     = p1_valid & p1_ready;
    assign acc      = acc0 | acc1;
    assign acc_we   = acc1 ? p1_we : p0_we;

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        burst_nxt = burst_cnt;
        own_valid = (state == GRANT1) ? p1_valid : p0_valid;
        oth_valid = (state == GRANT1) ? p0_valid : p1_valid;
        burst_inc = burst_cnt + {7'd0, acc};
        case (state)
            IDLE: begin
                if (p0_valid && (!p1_valid || last)) begin
                    state_nxt = GRANT0;
                    last_nxt  = 1'b0;
                    burst_nxt = 8'd0;
                end else if (p1_valid) begin
                    state_nxt = GRANT1;
                    last_nxt  = 1'b1;
                    burst_nxt = 8'd0;
                end
            end
            GRANT0, GRANT1: begin
                burst_nxt = burst_inc;
                if (!own_valid || (acc && burst_inc == 8'(MAX_BURST))) begin
                    // Hand over directly when the other side waits; otherwise re-grant or idle.
                    burst_nxt = 8'd0;
                    if (oth_valid) begin
                        state_nxt = (state == GRANT0) ? GRANT1 : GRANT0;
                        last_nxt  = (state == GRANT0);
                    end else if (!own_valid) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            last      <= 1'b1;
            burst_cnt <= 8'd0;
        end else begin
            state     <= state_nxt;
            last      <= last_nxt;
            burst_cnt <= burst_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_valid <= acc;
            if (acc) begin
                mem_we    <= acc_we;
                mem_addr  <= acc1 ? p1_addr  : p0_addr;
                mem_wdata <= acc1 ? p1_wdata : p0_wdata;
            end
        end
    end

    // Tag slot k holds the beat accepted k+1 cycles ago; the tail lines up with mem_read_data.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_vld   <= '0;
            tag_port  <= '0;
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
            p0_rdata  <= '0;
            p1_rdata  <= '0;
        end else begin
            tag_vld   <= {tag_vld[DEPTH-2:0], acc & ~acc_we};
            tag_port  <= {tag_port[DEPTH-2:0], acc1};
            p0_rvalid <= tag_vld[DEPTH-1] & ~tag_port[DEPTH-1];
            p1_rvalid <= tag_vld[DEPTH-1] &  tag_port[DEPTH-1];
            if (tag_vld[DEPTH-1] && !tag_port[DEPTH-1]) p0_rdata <= mem_read_data;
            if (tag_vld[DEPTH-1] &&  tag_port[DEPTH-1]) p1_rdata <= mem_read_data;
        end
    end
endmodule

// File: tb/tb_sram_arbiter.sv
// Randomized bench for sram_arbiter against a transaction-level reference model.
module tb_sram_arbiter;
    localparam int AB = 20, DB = 16, MB = 8, RL = 2;

    logic          clk = 1'b0, reset;
    logic          p0_valid, p0_ready, p0_we, p0_rvalid;
    logic          p1_valid, p1_ready, p1_we, p1_rvalid;
    logic [AB-1:0] p0_addr, p1_addr, mem_addr;
    logic [DB-1:0] p0_wdata, p1_wdata, p0_rdata, p1_rdata, mem_wdata, mem_read_data;
    logic          mem_valid, mem_we;

    always #5 clk = ~clk;

    sram_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .MAX_BURST(MB), .READ_LATENCY(RL)) dut (
        .clk(clk), .reset(reset),
        .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_rdata(p0_rdata), .p0_rvalid(p0_rvalid),
        .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_we(p1_we), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_rdata(p1_rdata), .p1_rvalid(p1_rvalid),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_read_data(mem_read_data)
    );

    typedef struct {int due; int port; logic [DB-1:0] data;} ret_t;

    int            n_vec = 0, n_err = 0, cyc = 0;
    int            owner, last, beats;
    logic          m_mv, m_we;
    logic [AB-1:0] m_addr;
    logic [DB-1:0] m_wd;
    logic [DB-1:0] m_rd [2];
    ret_t          eq[$];  // expected rvalid strobes
    ret_t          dq[$];  // controller read data to present

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        owner = -1; last = 1; beats = 0;
        m_mv = 0; m_we = 0; m_addr = '0; m_wd = '0;
        m_rd[0] = '0; m_rd[1] = '0;
        eq.delete(); dq.delete();
    endtask

    int pct0 [7] = '{100, 100, 50, 90, 20, 0, 60};
    int pct1 [7] = '{100, 0, 50, 30, 20, 100, 60};
    int rpct [7] = '{0, 0, 1, 1, 0, 0, 2};

    initial begin
        logic          v [2], w [2];
        logic [AB-1:0] a [2];
        logic [DB-1:0] d [2];
        logic          rv [2];
        logic [DB-1:0] rd;
        int            o;

        reset = 1'b1;
        {p0_valid, p0_we, p1_valid, p1_we} = '0;
        p0_addr = '0; p1_addr = '0; p0_wdata = '0; p1_wdata = '0;
        mem_read_data = '0;
        model_reset();
        @(posedge clk);

        for (int ph = 0; ph < 7; ph++) begin
            for (int i = 0; i < 300; i++) begin
                @(negedge clk);
                rv[0] = 0; rv[1] = 0;
                if (eq.size() > 0 && eq[0].due == cyc) begin
                    rv[eq[0].port] = 1;
                    m_rd[eq[0].port] = eq[0].data;
                    void'(eq.pop_front());
                end
                chk("p0_ready", p0_ready, owner == 0);
                chk("p1_ready", p1_ready, owner == 1);
                chk("mem_valid", mem_valid, m_mv);
                if (m_mv) chk("mem_we", mem_we, m_we);
                chk("mem_addr", mem_addr, m_addr);
                chk("mem_wdata", mem_wdata, m_wd);
                chk("p0_rvalid", p0_rvalid, rv[0]);
                chk("p1_rvalid", p1_rvalid, rv[1]);
                chk("p0_rdata", p0_rdata, m_rd[0]);
                chk("p1_rdata", p1_rdata, m_rd[1]);

                // Present read data only on its due cycle; garbage otherwise.
                if (dq.size() > 0 && dq[0].due == cyc) mem_read_data = dq.pop_front().data;
                else mem_read_data = DB'($urandom);

                reset = ($urandom_range(99) < rpct[ph]);
                v[0] = ($urandom_range(99) < pct0[ph]);
                v[1] = ($urandom_range(99) < pct1[ph]);
                for (int p = 0; p < 2; p++) begin
                    w[p] = $urandom_range(1);
                    a[p] = AB'($urandom);
                    d[p] = DB'($urandom);
                end
                p0_valid = v[0]; p0_we = w[0]; p0_addr = a[0]; p0_wdata = d[0];
                p1_valid = v[1]; p1_we = w[1]; p1_addr = a[1]; p1_wdata = d[1];

                // Reference step for the coming rising edge.
                if (reset) begin
                    model_reset();
                end else if (owner < 0) begin
                    m_mv = 0;
                    if (v[0] && v[1]) owner = (last == 0) ? 1 : 0;
                    else if (v[0]) owner = 0;
                    else if (v[1]) owner = 1;
                    if (owner >= 0) begin last = owner; beats = 0; end
                end else begin
                    m_mv = v[owner];
                    if (m_mv) begin
                        m_we = w[owner]; m_addr = a[owner]; m_wd = d[owner];
                        beats++;
                        if (!w[owner]) begin
                            rd = DB'($urandom);
                            dq.push_back('{cyc + 1 + RL, owner, rd});
                            eq.push_back('{cyc + 2 + RL, owner, rd});
                        end
                    end
                    if (!v[owner] || beats == MB) begin
                        o = 1 - owner;
                        beats = 0;
                        if (v[o]) begin owner = o; last = o; end
                        else if (!v[owner]) owner = -1;
                    end
                end
                cyc++;
                @(posedge clk);
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
